// File: rtl/jelly3_img_mosaic_bayer_core.sv
// Re-mosaics an {R,G,B} pixel stream into a single-channel Bayer raw stream (2-cycle latency).
// Optional colour-index output enabled by defining JELLY3_IMG_MOSAIC_BAYER_COLOR_ID_EN.
module jelly3_img_mosaic_bayer_core #(
    parameter int DATA_BITS = 10,
    parameter int USER_BITS = 1,
    parameter int USE_VALID = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cke,
    input  logic [1:0]             param_phase,
    input  logic                   s_img_row_first,
    input  logic                   s_img_row_last,
    input  logic                   s_img_col_first,
    input  logic                   s_img_col_last,
    input  logic                   s_img_de,
    input  logic [USER_BITS-1:0]   s_img_user,
    input  logic [3*DATA_BITS-1:0] s_img_data,
    input  logic                   s_img_valid,
    output logic                   m_img_row_first,
    output logic                   m_img_row_last,
    output logic                   m_img_col_first,
    output logic                   m_img_col_last,
    output logic                   m_img_de,
    output logic [USER_BITS-1:0]   m_img_user,
    output logic [DATA_BITS-1:0]   m_img_data,
    output logic                   m_img_valid
`ifdef JELLY3_IMG_MOSAIC_BAYER_COLOR_ID_EN
    ,
    output logic [1:0]             m_img_color
`endif
);

    logic                 in_valid;
    logic                 frame_start;
    logic [1:0]           phase_eff;
    logic                 x_eff;
    logic                 y_eff;
    logic [1:0]           idx;
    logic [DATA_BITS-1:0] sel_data;

    logic                 x_q, x_d;
    logic                 y_q, y_d;
    logic [1:0]           phase_lat_q, phase_lat_d;

    logic                 s1_rf_q, s1_rl_q, s1_cf_q, s1_cl_q, s1_de_q, s1_valid_q;
    logic [USER_BITS-1:0] s1_user_q;
    logic [DATA_BITS-1:0] s1_data_q;

    logic                 s2_rf_q, s2_rl_q, s2_cf_q, s2_cl_q, s2_de_q, s2_valid_q;
    logic [USER_BITS-1:0] s2_user_q;
    logic [DATA_BITS-1:0] s2_data_q;

    assign in_valid    = (USE_VALID != 0) ? s_img_valid : 1'b1;
    assign frame_start = in_valid & s_img_row_first & s_img_col_first;

    // The frame-start pixel already uses the freshly captured phase.
    always_comb begin
        phase_eff   = frame_start ? param_phase : phase_lat_q;
        x_eff       = s_img_col_first ? 1'b0 : x_q;
        if (s_img_row_first && s_img_col_first) begin
            y_eff = 1'b0;
        end else if (s_img_col_first) begin
            y_eff = ~y_q;
        end else begin
            y_eff = y_q;
        end
        idx         = {y_eff, x_eff} ^ phase_eff;
        x_d         = in_valid ? ~x_eff : x_q;
        y_d         = in_valid ? y_eff : y_q;
        phase_lat_d = frame_start ? param_phase : phase_lat_q;
    end

    always_comb begin
        sel_data = '0;
        case (idx)
            2'd0:    sel_data = s_img_data[3*DATA_BITS-1 -: DATA_BITS];
            2'd1,
            2'd2:    sel_data = s_img_data[2*DATA_BITS-1 -: DATA_BITS];
            default: sel_data = s_img_data[DATA_BITS-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q         <= 1'b0;
            y_q         <= 1'b0;
            phase_lat_q <= '0;
            s1_rf_q     <= 1'b0;
            s1_rl_q     <= 1'b0;
            s1_cf_q     <= 1'b0;
            s1_cl_q     <= 1'b0;
            s1_de_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_user_q   <= '0;
            s1_data_q   <= '0;
            s2_rf_q     <= 1'b0;
            s2_rl_q     <= 1'b0;
            s2_cf_q     <= 1'b0;
            s2_cl_q     <= 1'b0;
            s2_de_q     <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_user_q   <= '0;
            s2_data_q   <= '0;
        end else if (cke) begin
            x_q         <= x_d;
            y_q         <= y_d;
            phase_lat_q <= phase_lat_d;

            s1_rf_q     <= s_img_row_first & in_valid;
            s1_rl_q     <= s_img_row_last  & in_valid;
            s1_cf_q     <= s_img_col_first & in_valid;
            s1_cl_q     <= s_img_col_last  & in_valid;
            s1_de_q     <= s_img_de        & in_valid;
            s1_valid_q  <= in_valid;
            s1_user_q   <= s_img_user;
            s1_data_q   <= sel_data;

            s2_rf_q     <= s1_rf_q;
            s2_rl_q     <= s1_rl_q;
            s2_cf_q     <= s1_cf_q;
            s2_cl_q     <= s1_cl_q;
            s2_de_q     <= s1_de_q;
            s2_valid_q  <= s1_valid_q;
            s2_user_q   <= s1_user_q;
            s2_data_q   <= s1_de_q ? s1_data_q : '0;
        end
    end

    assign m_img_row_first = s2_rf_q;
    assign m_img_row_last  = s2_rl_q;
    assign m_img_col_first = s2_cf_q;
    assign m_img_col_last  = s2_cl_q;
    assign m_img_de        = s2_de_q;
    assign m_img_user      = s2_user_q;
    assign m_img_data      = s2_data_q;
    assign m_img_valid     = (USE_VALID != 0) ? s2_valid_q : 1'b1;

`ifdef JELLY3_IMG_MOSAIC_BAYER_COLOR_ID_EN
    logic [1:0] s1_idx_q;
    logic [1:0] s2_idx_q;

    // Colour index is reported even on blanking pixels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_idx_q <= '0;
            s2_idx_q <= '0;
        end else if (cke) begin
            s1_idx_q <= idx;
            s2_idx_q <= s1_idx_q;
        end
    end

    assign m_img_color = s2_idx_q;
`endif

endmodule

// File: tb/tb_jelly3_img_mosaic_bayer_core.sv
// Self-checking bench for jelly3_img_mosaic_bayer_core: table frames plus scoreboarded corner sequences.
module tb_jelly3_img_mosaic_bayer_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cke = 1'b1;
    logic [1:0]  param_phase = '0;
    logic        s_img_row_first = 1'b0, s_img_row_last = 1'b0;
    logic        s_img_col_first = 1'b0, s_img_col_last = 1'b0;
    logic        s_img_de = 1'b0, s_img_valid = 1'b0;
    logic [0:0]  s_img_user = '0;
    logic [29:0] s_img_data = '0;
    logic        m_img_row_first, m_img_row_last, m_img_col_first, m_img_col_last;
    logic        m_img_de, m_img_valid;
    logic [0:0]  m_img_user;
    logic [9:0]  m_img_data;
`ifdef JELLY3_IMG_MOSAIC_BAYER_COLOR_ID_EN
    logic [1:0]  m_img_color;
`endif

    jelly3_img_mosaic_bayer_core #(
        .DATA_BITS(10),
        .USER_BITS(1),
        .USE_VALID(1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cke            (cke),
        .param_phase    (param_phase),
        .s_img_row_first(s_img_row_first),
        .s_img_row_last (s_img_row_last),
        .s_img_col_first(s_img_col_first),
        .s_img_col_last (s_img_col_last),
        .s_img_de       (s_img_de),
        .s_img_user     (s_img_user),
        .s_img_data     (s_img_data),
        .s_img_valid    (s_img_valid),
        .m_img_row_first(m_img_row_first),
        .m_img_row_last (m_img_row_last),
        .m_img_col_first(m_img_col_first),
        .m_img_col_last (m_img_col_last),
        .m_img_de       (m_img_de),
        .m_img_user     (m_img_user),
        .m_img_data     (m_img_data),
        .m_img_valid    (m_img_valid)
`ifdef JELLY3_IMG_MOSAIC_BAYER_COLOR_ID_EN
        ,
        .m_img_color    (m_img_color)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  d;
        logic [1:0]  col;
        logic [3:0]  flags;
        logic        de;
        logic [0:0]  user;
        int unsigned t;
    } exp_t;

    typedef struct {
        logic [1:0]  ph;
        int unsigned r;
        int unsigned c;
        logic [9:0]  exp;
    } vec_t;

    exp_t        sb[$];
    exp_t        cur_exp;
    vec_t        tbl[16];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned en_cnt = 0;
    logic        last_en = 1'b0;
    logic        last_cke_low = 1'b0;
    logic [17:0] snap = '0;

    // Push expectations at each accepting edge; pop and compare when output appears.
    always @(posedge clk) begin
        last_en      = cke && reset_n;
        last_cke_low = !cke && reset_n;
        if (cke && reset_n) begin
            if (s_img_valid) begin
                cur_exp.t = en_cnt;
                sb.push_back(cur_exp);
            end
            en_cnt++;
        end
    end

    always @(negedge clk) begin
        logic [17:0] now;
        exp_t e;
        now = {m_img_row_first, m_img_row_last, m_img_col_first, m_img_col_last,
               m_img_de, m_img_user, m_img_data, m_img_valid, 2'b00};
        if (last_cke_low) begin
            checks++;
            if (now !== snap) begin
                errors++;
                $display("FAIL freeze got=%h required=%h", now, snap);
            end
        end else if (last_en && m_img_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got data=%0d required none", m_img_data);
            end else begin
                e = sb.pop_front();
                checks++;
                if (m_img_data !== e.d) begin
                    errors++;
                    $display("FAIL data got=%0d required=%0d", m_img_data, e.d);
                end
                checks++;
                if ({m_img_row_first, m_img_row_last, m_img_col_first, m_img_col_last,
                     m_img_de, m_img_user} !== {e.flags, e.de, e.user}) begin
                    errors++;
                    $display("FAIL sideband got=%b required=%b",
                             {m_img_row_first, m_img_row_last, m_img_col_first, m_img_col_last,
                              m_img_de, m_img_user}, {e.flags, e.de, e.user});
                end
                checks++;
                if (en_cnt - e.t != 2) begin
                    errors++;
                    $display("FAIL latency got=%0d required=2", en_cnt - e.t);
                end
`ifdef JELLY3_IMG_MOSAIC_BAYER_COLOR_ID_EN
                checks++;
                if (m_img_color !== e.col) begin
                    errors++;
                    $display("FAIL color got=%0d required=%0d", m_img_color, e.col);
                end
`endif
            end
        end
        snap = now;
    end

    task automatic drive(input logic rf, input logic rl, input logic cf, input logic cl,
                         input logic de, input logic vld, input logic [29:0] rgb,
                         input logic [9:0] ed, input logic [1:0] ec);
        @(negedge clk);
        cke             = 1'b1;
        s_img_row_first = rf;
        s_img_row_last  = rl;
        s_img_col_first = cf;
        s_img_col_last  = cl;
        s_img_de        = de;
        s_img_valid     = vld;
        s_img_data      = rgb;
        s_img_user      = 1'($urandom_range(0, 1));
        cur_exp.d       = ed;
        cur_exp.col     = ec;
        cur_exp.flags   = {rf, rl, cf, cl};
        cur_exp.de      = de;
        cur_exp.user    = s_img_user;
    endtask

    function automatic logic [29:0] pix_rgb(input int unsigned r, input int unsigned c);
        return {10'(100 + c), 10'(200 + c), 10'(300 + r)};
    endfunction

    function automatic logic [1:0] pix_idx(input int unsigned r, input int unsigned c,
                                           input logic [1:0] ph);
        return {1'(r % 2), 1'(c % 2)} ^ ph;
    endfunction

    // Model pixel: colour chosen from absolute row/column parity and frame phase.
    task automatic px(input int unsigned r, input int unsigned c, input logic [1:0] ph,
                      input logic de);
        logic [29:0] rgb;
        logic [1:0]  idx;
        logic [9:0]  ed;
        rgb = pix_rgb(r, c);
        idx = pix_idx(r, c, ph);
        case (idx)
            2'd0:    ed = rgb[29:20];
            2'd3:    ed = rgb[9:0];
            default: ed = rgb[19:10];
        endcase
        if (!de) ed = '0;
        drive(r == 0, r == 1, c == 0, c == 3, de, 1'b1, rgb, ed, idx);
    endtask

    task automatic idle();
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 30'($urandom), '0, '0);
    endtask

    task automatic cke_low(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            cke = 1'b0;
        end
    endtask

    task automatic run_tbl(input int unsigned base, input logic gaps);
        for (int unsigned i = base; i < base + 8; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle();
            param_phase = tbl[i].ph;
            drive(tbl[i].r == 0, tbl[i].r == 1, tbl[i].c == 0, tbl[i].c == 3, 1'b1, 1'b1,
                  pix_rgb(tbl[i].r, tbl[i].c), tbl[i].exp,
                  pix_idx(tbl[i].r, tbl[i].c, tbl[i].ph));
            if (gaps && i == base + 5) cke_low(3);
        end
    endtask

    initial begin
        int e0[8];
        int e3[8];
        e0 = '{100, 201, 102, 203, 200, 301, 202, 301};
        e3 = '{300, 201, 300, 203, 200, 101, 202, 103};
        for (int unsigned i = 0; i < 8; i++) begin
            tbl[i]     = '{2'd0, i / 4, i % 4, 10'(e0[i])};
            tbl[i + 8] = '{2'd3, i / 4, i % 4, 10'(e3[i])};
        end

        #12;
        checks++;
        if ({m_img_row_first, m_img_row_last, m_img_col_first, m_img_col_last, m_img_de,
             m_img_user, m_img_data, m_img_valid} !== '0) begin
            errors++;
            $display("FAIL reset_state got data=%0d valid=%b required 0", m_img_data, m_img_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;

        run_tbl(0, 1'b0);
        run_tbl(8, 1'b0);
        repeat (3) idle();

        // Mid-frame phase change is deferred to the next frame start.
        param_phase = 2'd0;
        for (int unsigned c = 0; c < 4; c++) px(0, c, 2'd0, 1'b1);
        px(1, 0, 2'd0, 1'b1);
        px(1, 1, 2'd0, 1'b1);
        param_phase = 2'd1;
        px(1, 2, 2'd0, 1'b1);
        px(1, 3, 2'd0, 1'b1);
        for (int unsigned i = 0; i < 8; i++) px(i / 4, i % 4, 2'd1, 1'b1);

        run_tbl(0, 1'b1);
        repeat (3) idle();

        // Blanking pixel: zero output, parity still advances.
        param_phase = 2'd0;
        for (int unsigned i = 0; i < 8; i++) px(i / 4, i % 4, 2'd0, !(i == 1));

        // Asynchronous reset in the middle of a row.
        param_phase = 2'd2;
        px(0, 0, 2'd2, 1'b1);
        px(0, 1, 2'd2, 1'b1);
        @(negedge clk);
        #2;
        reset_n     = 1'b0;
        s_img_valid = 1'b0;
        #1;
        checks++;
        if ({m_img_row_first, m_img_row_last, m_img_col_first, m_img_col_last, m_img_de,
             m_img_user, m_img_data, m_img_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset got data=%0d valid=%b required 0", m_img_data, m_img_valid);
        end
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        px(0, 2, 2'd0, 1'b1);
        px(0, 3, 2'd0, 1'b1);
        for (int unsigned i = 0; i < 8; i++) px(i / 4, i % 4, 2'd2, 1'b1);

        idle();
        for (int k = 0; k < 50 && sb.size() != 0; k++) idle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
